apb_bridge_ctrl: RTL

APB_BRIDGE_CTRL -- requirements
Module: apb_bridge_ctrl

---
 rtl/bridge_pkg.sv | 37 +++
 rtl/apb_addr_decode.sv | 27 ++
 rtl/apb_bridge_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// Shared AHB-to-APB bridge types: FSM states, HTRANS/HRESP codes, slave address map.
// Latency: n/a (declarations only).
// Backpressure: n/a. ST_ERR1/ST_ERR2 exist only when BRIDGE_ERR_RESP_EN is defined.
package bridge_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    // Three 64 MiB APB windows, contiguous from 0x8000_0000
    localparam logic [31:0] SLV0_BASE  = 32'h8000_0000;
    localparam logic [31:0] SLV0_LIMIT = 32'h83FF_FFFF;
    localparam logic [31:0] SLV1_BASE  = 32'h8400_0000;
    localparam logic [31:0] SLV1_LIMIT = 32'h87FF_FFFF;
    localparam logic [31:0] SLV2_BASE  = 32'h8800_0000;
    localparam logic [31:0] SLV2_LIMIT = 32'h8BFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WWAIT,
        ST_READ,
        ST_RENABLE,
        ST_WRITE,
`ifdef BRIDGE_ERR_RESP_EN
        ST_WENABLE,
        ST_ERR1,
        ST_ERR2
`else
        ST_WENABLE
`endif
    } state_t;

endpackage

// File: rtl/apb_addr_decode.sv
// Address decoder: AHB address to one-hot APB slave select plus hit flag.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module apb_addr_decode #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [2:0]        sel,
    output logic              hit
);
    import bridge_pkg::*;

    // Widen so the compare works for any ADDR_W against the 32-bit map constants
    logic [63:0] addr_ext;
    assign addr_ext = 64'(addr);

    // One range compare per slave window
    always_comb begin
        sel = 3'b000;
        if (addr_ext >= 64'(SLV0_BASE) && addr_ext <= 64'(SLV0_LIMIT)) sel[0] = 1'b1;
        if (addr_ext >= 64'(SLV1_BASE) && addr_ext <= 64'(SLV1_LIMIT)) sel[1] = 1'b1;
        if (addr_ext >= 64'(SLV2_BASE) && addr_ext <= 64'(SLV2_LIMIT)) sel[2] = 1'b1;
    end

    assign hit = |sel;

endmodule

// File: rtl/apb_bridge_ctrl.sv
// AHB-lite to APB bridge controller; BRIDGE_ERR_RESP_EN adds a two-cycle ERROR response for unmapped addresses.
// Latency: read completes 2 cycles after its address phase, write 3 cycles.
// Backpressure: Hreadyout low during setup/wait states; a new transfer is taken in IDLE or either enable state.
module apb_bridge_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              Hresetn,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic              Hwrite,
    input  logic [1:0]        Htrans,
    input  logic              Hreadyin,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [DATA_W-1:0] Prdata,
    output logic              Hreadyout,
    output logic [1:0]        Hresp,
    output logic [DATA_W-1:0] Hrdata,
    output logic [2:0]        Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata
);
    import bridge_pkg::*;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_r;
    logic              wr_r;
    logic [2:0]        sel_r;
    logic [DATA_W-1:0] wdata_r;
    logic [2:0]        dec_sel;
    logic              dec_hit;
    logic              accept_pt;
    logic              xfer_req;
    logic              valid;
    logic              accept;

    apb_addr_decode #(.ADDR_W(ADDR_W)) u_dec (
        .addr (Haddr),
        .sel  (dec_sel),
        .hit  (dec_hit)
    );

    // States in which a new address phase may be taken
    assign accept_pt = (state == ST_IDLE) || (state == ST_RENABLE) || (state == ST_WENABLE);

    // Kept outside the FSM comb block: valid depends on Hreadyout, and the
    // next-state logic depends on valid, so merging them would form a loop.
`ifdef BRIDGE_ERR_RESP_EN
    assign Hreadyout = accept_pt || (state == ST_ERR2);
`else
    assign Hreadyout = accept_pt;
`endif

    assign xfer_req = Hreadyin && Hreadyout &&
                      ((Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_SEQ));
    assign valid    = xfer_req && dec_hit;
    assign accept   = valid && accept_pt;

    assign Paddr  = addr_r;
    assign Pwdata = wdata_r;

    // State register; reset aborts any transfer in flight
    always_ff @(posedge clock or negedge Hresetn) begin
        if (!Hresetn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Capture address, direction and decode on acceptance; write data in its data phase
    always_ff @(posedge clock or negedge Hresetn) begin
        if (!Hresetn) begin
            addr_r  <= '0;
            wr_r    <= 1'b0;
            sel_r   <= 3'b000;
            wdata_r <= '0;
        end else begin
            if (accept) begin
                addr_r <= Haddr;
                wr_r   <= Hwrite;
                sel_r  <= dec_sel;
            end
            if (state == ST_WWAIT) wdata_r <= Hwdata;
        end
    end

    // Next-state and APB/AHB output decode
    always_comb begin
        state_nxt = state;
        Pselx     = 3'b000;
        Penable   = 1'b0;
        Pwrite    = 1'b0;
        Hresp     = HRESP_OKAY;
        Hrdata    = '0;
        case (state)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (state != ST_IDLE) begin
                    Pselx   = sel_r;
                    Penable = 1'b1;
                    Pwrite  = wr_r;
                end
                if (state == ST_RENABLE) Hrdata = Prdata;
                if (valid)            state_nxt = Hwrite ? ST_WWAIT : ST_READ;
`ifdef BRIDGE_ERR_RESP_EN
                else if (xfer_req)    state_nxt = ST_ERR1;
`endif
                else                  state_nxt = ST_IDLE;
            end
            ST_WWAIT: state_nxt = ST_WRITE;
            ST_READ, ST_WRITE: begin
                Pselx     = sel_r;
                Pwrite    = wr_r;
                state_nxt = (state == ST_READ) ? ST_RENABLE : ST_WENABLE;
            end
`ifdef BRIDGE_ERR_RESP_EN
            ST_ERR1: begin
                Hresp     = HRESP_ERROR;
                state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                Hresp     = HRESP_ERROR;
                state_nxt = ST_IDLE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
